// File: rtl/beat_pkg.sv
// beat_pkg: shared FSM states, tempo codes and lead-in length for the beat generator.
package beat_pkg;
    typedef enum logic [2:0] {IDLE, LEADIN, RUN, PAUSE, DONE} state_t;
    typedef enum logic [1:0] {TEMPO_SLOW, TEMPO_MED, TEMPO_FAST, TEMPO_FAST_ALT} tempo_t;
    localparam int LEADIN_BEATS = 4;
endpackage

// File: rtl/beat_divider.sv
// beat_divider: latched tempo period and phase counter producing wrap and mid-beat pulses.
module beat_divider
    import beat_pkg::*;
#(
    parameter int P_SLOW = 600,
    parameter int P_MED  = 400,
    parameter int P_FAST = 300
) (
    input  logic   clk,
    input  logic   n_rst,
    input  logic   load,
    input  logic   clear,
    input  logic   en,
    input  tempo_t tempo_sel,
    output logic   wrap,
    output logic   half_wrap
);
    localparam int P_MAX = (P_SLOW > P_MED) ? ((P_SLOW > P_FAST) ? P_SLOW : P_FAST)
                                            : ((P_MED > P_FAST) ? P_MED : P_FAST);
    localparam int W = $clog2(P_MAX);

    // Periods are stored minus one so a power-of-two P still fits in W bits.
    logic [W-1:0] period_m1, half_m1, div_cnt, sel_m1, sel_half;

    assign sel_m1 = tempo_sel == TEMPO_SLOW ? W'(P_SLOW - 1) :
                    tempo_sel == TEMPO_MED  ? W'(P_MED - 1)  : W'(P_FAST - 1);
    assign sel_half = tempo_sel == TEMPO_SLOW ? W'(P_SLOW / 2 - 1) :
                      tempo_sel == TEMPO_MED  ? W'(P_MED / 2 - 1)  : W'(P_FAST / 2 - 1);
    assign wrap = en && div_cnt == period_m1;
    assign half_wrap = en && div_cnt == half_m1;

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            period_m1 <= '0;
            half_m1 <= '0;
            div_cnt <= '0;
        end else begin
            if (load) begin
                period_m1 <= sel_m1;
                half_m1 <= sel_half;
            end
            div_cnt <= clear ? '0 : !en ? div_cnt : wrap ? '0 : div_cnt + 1'b1;
        end
    end
endmodule

// File: rtl/beat_generator.sv
// beat_generator: start/pause/done controlled beat timebase with three selectable tempos.
// Defining BEAT_LEADIN_EN adds a four-strobe count-in before the first beat.
module beat_generator
    import beat_pkg::*;
#(
    parameter int CLK_FREQ_HZ = 10_000_000,
    parameter int BPM_SLOW    = 60,
    parameter int BPM_MED     = 90,
    parameter int BPM_FAST    = 120
) (
    input  logic       clk,
    input  logic       n_rst,
    input  logic       start,
    input  logic       pause,
    input  logic       finish,
    input  logic [1:0] tempo_sel,
    output logic       beat_clk,
    output logic       half_beat,
    output logic       count_in,
    output logic [5:0] beat_idx,
    output logic       running
);
`ifdef BEAT_LEADIN_EN
    localparam bit LEADIN_EN = 1'b1;
`else
    localparam bit LEADIN_EN = 1'b0;
`endif
    localparam state_t START_STATE = LEADIN_EN ? LEADIN : RUN;
    localparam int LW = $clog2(LEADIN_BEATS);

    state_t state, state_nxt, ret_state, mode;
    logic [LW-1:0] lead_cnt;
    logic accept, active, en, clear, wrap, half_wrap, lead_last;

    assign accept = start && (state == IDLE || state == DONE);
    assign active = state == LEADIN || state == RUN || state == PAUSE;
    assign en = active && !finish && !pause;
    // While paused, strobes and transitions act on the state the song was frozen in.
    assign mode = state == PAUSE ? ret_state : state;
    assign lead_last = mode == LEADIN && wrap && lead_cnt == LW'(LEADIN_BEATS - 1);
    assign clear = accept || state_nxt == IDLE || state_nxt == DONE;
    assign running = state == LEADIN || state == RUN;

    beat_divider #(
        .P_SLOW(CLK_FREQ_HZ * 60 / BPM_SLOW),
        .P_MED (CLK_FREQ_HZ * 60 / BPM_MED),
        .P_FAST(CLK_FREQ_HZ * 60 / BPM_FAST)
    ) u_div (
        .clk      (clk),
        .n_rst    (n_rst),
        .load     (accept),
        .clear    (clear),
        .en       (en),
        .tempo_sel(tempo_t'(tempo_sel)),
        .wrap     (wrap),
        .half_wrap(half_wrap)
    );

    always_comb begin
        state_nxt = state;
        if (!active)
            state_nxt = start ? START_STATE : state;
        else
            state_nxt = finish ? DONE : pause ? PAUSE : lead_last ? RUN : mode;
    end

    always_ff @(posedge clk or negedge n_rst) begin
        if (!n_rst) begin
            state <= IDLE;
            ret_state <= IDLE;
            lead_cnt <= '0;
            beat_idx <= '0;
            beat_clk <= 1'b0;
            half_beat <= 1'b0;
            count_in <= 1'b0;
        end else begin
            state <= state_nxt;
            if (state != PAUSE)
                ret_state <= state;
            lead_cnt <= (accept || lead_last) ? '0 : (wrap && mode == LEADIN) ? lead_cnt + 1'b1 : lead_cnt;
            beat_idx <= accept ? '0 : (wrap && mode == RUN) ? beat_idx + 1'b1 : beat_idx;
            beat_clk <= wrap && mode == RUN;
            half_beat <= half_wrap && mode == RUN;
            count_in <= LEADIN_EN && wrap && mode == LEADIN;
        end
    end
endmodule

// File: tb/tb_beat_generator.sv
// tb_beat_generator: scoreboarded strobe timing for beat_generator at CLK_FREQ_HZ=600.
module tb_beat_generator;
    localparam int CLK_HZ = 600;
`ifdef BEAT_LEADIN_EN
    localparam int LEAD = 4;
`else
    localparam int LEAD = 0;
`endif
    localparam int K_BEAT = 0, K_HALF = 1, K_CNT = 2;

    logic clk = 1'b0, n_rst = 1'b0, start = 1'b0, pause = 1'b0, finish = 1'b0;
    logic [1:0] tempo_sel = 2'd0;
    logic beat_clk, half_beat, count_in, running;
    logic [5:0] beat_idx;
    int cyc = 0, checks = 0, errors = 0;

    typedef struct { int kind; int t; int idx; } ev_t;
    typedef struct { logic [1:0] tsel; int period; } vec_t;
    ev_t sb[$];
    vec_t vecs[4];

    beat_generator #(.CLK_FREQ_HZ(CLK_HZ)) dut (
        .clk      (clk),
        .n_rst    (n_rst),
        .start    (start),
        .pause    (pause),
        .finish   (finish),
        .tempo_sel(tempo_sel),
        .beat_clk (beat_clk),
        .half_beat(half_beat),
        .count_in (count_in),
        .beat_idx (beat_idx),
        .running  (running)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %0d, expected %0d", nm, cyc, act, exp);
        end
    endtask

    task automatic see(input logic s, input int k, input string nm);
        if (s) begin
            checks++;
            if (sb.size() == 0 || sb[0].t != cyc) begin
                errors++;
                $display("FAIL %s unexpected at cycle %0d (next expected at %0d)", nm, cyc,
                         sb.size() > 0 ? sb[0].t : -1);
            end else begin
                ev_t e;
                e = sb.pop_front();
                if (e.kind != k || e.idx != int'(beat_idx)) begin
                    errors++;
                    $display("FAIL %s at cycle %0d: got kind %0d idx %0d, expected kind %0d idx %0d",
                             nm, cyc, k, beat_idx, e.kind, e.idx);
                end
            end
        end
    endtask

    // Strobe monitor: every strobe must match the head of the scoreboard on its exact cycle.
    always @(negedge clk) begin
        while (sb.size() > 0 && sb[0].t < cyc) begin
            checks++;
            errors++;
            $display("FAIL missed strobe kind %0d due at cycle %0d, now %0d", sb[0].kind, sb[0].t, cyc);
            void'(sb.pop_front());
        end
        see(beat_clk, K_BEAT, "beat_clk");
        see(half_beat, K_HALF, "half_beat");
        see(count_in, K_CNT, "count_in");
    end

    task automatic run_to(input int t);
        while (cyc < t) @(negedge clk);
    endtask

    task automatic push_run(input int t0, input int p, input int n, input int idx0);
        for (int k = 0; k < n; k++) begin
            sb.push_back('{K_HALF, t0 + k * p + p / 2, idx0 + k});
            sb.push_back('{K_BEAT, t0 + (k + 1) * p, idx0 + k + 1});
        end
    endtask

    // Returns the cycle at which RUN phase counting begins (after any count-in).
    task automatic do_start(input logic [1:0] ts, input int p, output int t_run);
        int t;
        @(negedge clk);
        start = 1'b1;
        tempo_sel = ts;
        t = cyc + 1;
        @(negedge clk);
        start = 1'b0;
        for (int k = 1; k <= LEAD; k++) sb.push_back('{K_CNT, t + k * p, 0});
        t_run = t + LEAD * p;
        chk("idx_cleared_on_start", int'(beat_idx), 0);
        chk("running_after_start", int'(running), 1);
    endtask

    task automatic chk_all_zero(input string nm);
        chk({nm, "_beat_clk"}, int'(beat_clk), 0);
        chk({nm, "_half_beat"}, int'(half_beat), 0);
        chk({nm, "_count_in"}, int'(count_in), 0);
        chk({nm, "_beat_idx"}, int'(beat_idx), 0);
        chk({nm, "_running"}, int'(running), 0);
    endtask

    initial begin
        #500_000;
        $display("FAIL watchdog expired at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        int t;
        vecs[0] = '{2'd0, 600};
        vecs[1] = '{2'd1, 400};
        vecs[2] = '{2'd2, 300};
        vecs[3] = '{2'd3, 300};
        repeat (3) @(negedge clk);
        chk_all_zero("reset");
        n_rst = 1'b1;
        repeat (20) @(negedge clk);
        chk("idle_running", int'(running), 0);

        // Each tempo: three beats, then finish mid-beat and verify DONE holds beat_idx.
        foreach (vecs[i]) begin
            do_start(vecs[i].tsel, vecs[i].period, t);
            push_run(t, vecs[i].period, 3, 0);
            run_to(t + 3 * vecs[i].period + vecs[i].period / 4);
            chk("idx_after_3_beats", int'(beat_idx), 3);
            chk("running_in_run", int'(running), 1);
            finish = 1'b1;
            @(negedge clk);
            finish = 1'b0;
            chk("running_in_done", int'(running), 0);
            repeat (vecs[i].period / 2) @(negedge clk);
            chk("idx_held_in_done", int'(beat_idx), 3);
        end

        // Pause for 57 cycles mid-beat, then finish exactly on a wrap.
        do_start(2'd2, 300, t);
        push_run(t, 300, 1, 0);
        run_to(t + 400);
        pause = 1'b1;
        @(negedge clk);
        chk("running_in_pause", int'(running), 0);
        repeat (56) @(negedge clk);
        pause = 1'b0;
        @(negedge clk);
        chk("running_after_resume", int'(running), 1);
        push_run(t + 300 + 57, 300, 2, 1);
        sb.push_back('{K_HALF, t + 957 + 150, 3});
        run_to(t + 1256);
        finish = 1'b1;
        @(negedge clk);
        finish = 1'b0;
        chk("running_after_finish_on_wrap", int'(running), 0);
        chk("idx_after_finish_on_wrap", int'(beat_idx), 3);
        repeat (50) @(negedge clk);
        chk("idx_held_after_wrap_finish", int'(beat_idx), 3);

        // Restart from DONE at the slow tempo; a start and tempo change in RUN are ignored.
        do_start(2'd0, 600, t);
        push_run(t, 600, 2, 0);
        run_to(t + 700);
        start = 1'b1;
        tempo_sel = 2'd1;
        @(negedge clk);
        start = 1'b0;
        run_to(t + 1250);
        chk("idx_after_ignored_start", int'(beat_idx), 2);
        chk("running_after_ignored_start", int'(running), 1);
        chk("scoreboard_drained", sb.size(), 0);

        // Reset mid-beat clears everything immediately; no beats follow without start.
        n_rst = 1'b0;
        #1;
        chk_all_zero("async_reset");
        @(negedge clk);
        n_rst = 1'b1;
        repeat (700) @(negedge clk);
        chk("idx_after_reset_release", int'(beat_idx), 0);
        chk("running_after_reset_release", int'(running), 0);
        chk("scoreboard_empty_at_end", sb.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
